// File: rtl/routing_config_loader.sv
// Configuration loader: assembles a byte-stream frame into a shadow register, verifies an XOR
// checksum and commits the whole select vector to the routing fabric in a single edge.
module routing_config_loader #(
   parameter int unsigned CFG_WIDTH  = 900,
   parameter int unsigned WORD_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [WORD_WIDTH-1:0] in_data,
   input  logic                  in_valid,
   output logic                  in_ready,
   output logic [CFG_WIDTH-1:0]  cfg_out,
   output logic                  cfg_loaded,
   output logic                  busy,
   output logic                  err
);

   localparam int unsigned NWORDS = (CFG_WIDTH + WORD_WIDTH - 1) / WORD_WIDTH;
   localparam int unsigned CntW   = (NWORDS > 1) ? $clog2(NWORDS) : 1;
   localparam logic [CntW-1:0] LastCnt = CntW'(NWORDS - 1);

   localparam logic [1:0] StIdle  = 2'd0;
   localparam logic [1:0] StLoad  = 2'd1;
   localparam logic [1:0] StCheck = 2'd2;

   logic [1:0]            state_q, state_d;
   logic [CntW-1:0]       cnt_q, cnt_d;
   logic [WORD_WIDTH-1:0] acc_q, acc_d;
   logic [CFG_WIDTH-1:0]  shadow_q, shadow_d;
   logic [CFG_WIDTH-1:0]  cfg_q, cfg_d;
   logic                  loaded_q, loaded_d;
   logic                  err_q, err_d;
   logic                  ready_q, ready_d;

   logic                  accept;
   logic [CFG_WIDTH-1:0]  word_mask;
   logic [CFG_WIDTH-1:0]  word_data;

   assign accept = in_valid && ready_q;

   // The final word's mask and data fall off the top of the vector, truncating it.
   assign word_mask = {{(CFG_WIDTH - WORD_WIDTH){1'b0}}, {WORD_WIDTH{1'b1}}}
                      << (32'(cnt_q) * WORD_WIDTH);
   assign word_data = CFG_WIDTH'({NWORDS{in_data}});

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      acc_d    = acc_q;
      shadow_d = shadow_q;
      cfg_d    = cfg_q;
      loaded_d = loaded_q;
      err_d    = err_q;

      if (start) begin
         // Restart wins over any word presented in the same cycle.
         state_d = StLoad;
         cnt_d   = '0;
         acc_d   = '0;
         err_d   = 1'b0;
      end else begin
         case (state_q)
            StIdle: begin
               state_d = StIdle;
            end
            StLoad: begin
               if (accept) begin
                  shadow_d = (shadow_q & ~word_mask) | (word_data & word_mask);
                  acc_d    = acc_q ^ in_data;
                  if (cnt_q == LastCnt) begin
                     state_d = StCheck;
                  end else begin
                     cnt_d = cnt_q + 1'b1;
                  end
               end
            end
            StCheck: begin
               if (accept) begin
                  if (in_data == acc_q) begin
                     cfg_d    = shadow_q;
                     loaded_d = 1'b1;
                  end else begin
                     err_d = 1'b1;
                  end
                  state_d = StIdle;
               end
            end
            default: begin
               state_d = StIdle;
            end
         endcase
      end

      ready_d = (state_d == StLoad) || (state_d == StCheck);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= StIdle;
         cnt_q    <= '0;
         acc_q    <= '0;
         shadow_q <= '0;
         cfg_q    <= '0;
         loaded_q <= 1'b0;
         err_q    <= 1'b0;
         ready_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         acc_q    <= acc_d;
         shadow_q <= shadow_d;
         cfg_q    <= cfg_d;
         loaded_q <= loaded_d;
         err_q    <= err_d;
         ready_q  <= ready_d;
      end
   end

   assign in_ready   = ready_q;
   assign busy       = ready_q;
   assign cfg_out    = cfg_q;
   assign cfg_loaded = loaded_q;
   assign err        = err_q;

endmodule

// File: tb/tb_routing_config_loader.sv
// Self-checking bench for routing_config_loader: directed frame table, flow-control, abort and
// reset sequences, then randomized frames against a frame-level reference model.
module tb_routing_config_loader;

   localparam int CW = 900;
   localparam int WW = 8;
   localparam int NW = (CW + WW - 1) / WW;

   logic          clk = 1'b0;
   logic          rst;
   logic          start;
   logic [WW-1:0] in_data;
   logic          in_valid;
   logic          in_ready;
   logic [CW-1:0] cfg_out;
   logic          cfg_loaded;
   logic          busy;
   logic          err;

   routing_config_loader #(.CFG_WIDTH(CW), .WORD_WIDTH(WW)) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .in_data   (in_data),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .cfg_out   (cfg_out),
      .cfg_loaded(cfg_loaded),
      .busy      (busy),
      .err       (err)
   );

   always #5 clk = ~clk;

   typedef struct {
      int            idx;
      logic [WW-1:0] val;
      logic          bad;
      logic          exp_loaded;
      logic          exp_err;
   } vec_t;

   int n_chk  = 0;
   int n_fail = 0;
   int hs_cnt = 0;

   logic [WW-1:0] fw [NW];
   logic [WW-1:0] fck;
   logic [CW-1:0] exp_cfg;
   logic          exp_loaded;
   logic          exp_err;
   logic          glitch;

   // Handshakes the DUT should honour (start-cycle words are dropped).
   always @(posedge clk) if (!rst && in_valid && in_ready && !start) hs_cnt++;

   task automatic chk1(input string nm, input logic a, input logic e);
      n_chk++;
      if (a !== e) begin
         n_fail++;
         $display("FAIL %s: actual %b required %b", nm, a, e);
      end
   endtask

   task automatic chkn(input string nm, input int a, input int e);
      n_chk++;
      if (a != e) begin
         n_fail++;
         $display("FAIL %s: actual %0d required %0d", nm, a, e);
      end
   endtask

   task automatic chkv(input string nm, input logic [CW-1:0] a, input logic [CW-1:0] e);
      n_chk++;
      if (a !== e) begin
         int j;
         n_fail++;
         for (j = 0; j < CW; j++) if (a[j] !== e[j]) break;
         $display("FAIL %s: first bad bit %0d actual %b required %b", nm, j, a[j], e[j]);
      end
   endtask

   function automatic logic [CW-1:0] model_cfg();
      logic [CW-1:0] r = '0;
      for (int k = 0; k < NW; k++) r = r | (CW'(fw[k]) << (k * WW));
      return r;
   endfunction

   function automatic logic [WW-1:0] model_xor();
      logic [WW-1:0] x = '0;
      for (int k = 0; k < NW; k++) x = x ^ fw[k];
      return x;
   endfunction

   // Fabric must never change while a frame is in flight.
   task automatic mon();
      if (cfg_out !== exp_cfg || cfg_loaded !== exp_loaded) glitch = 1'b1;
   endtask

   task automatic do_start(input logic junk);
      start    = 1'b1;
      in_valid = junk;
      in_data  = WW'($urandom);
      @(posedge clk);
      @(negedge clk);
      start    = 1'b0;
      in_valid = 1'b0;
      exp_err  = 1'b0;
      mon();
   endtask

   task automatic send_word(input logic [WW-1:0] w, input logic gap);
      logic got = 1'b0;
      if (gap) begin
         in_valid = 1'b0;
         in_data  = WW'($urandom);
         @(posedge clk);
         @(negedge clk);
         mon();
      end
      in_valid = 1'b1;
      in_data  = w;
      for (int t = 0; t < 8; t++) begin
         got = in_ready;
         @(posedge clk);
         @(negedge clk);
         if (got) break;
         mon();
      end
      in_valid = 1'b0;
      if (!got) begin
         n_chk++;
         n_fail++;
         $display("FAIL ready_timeout: actual in_ready 0 required 1");
      end
   endtask

   // Sends fw/fck after a start pulse, then updates the reference model.
   task automatic run_frame(input int gapmode, input logic junk);
      logic good;
      glitch = 1'b0;
      do_start(junk);
      for (int k = 0; k < NW; k++) begin
         send_word(fw[k], (gapmode == 1) || (gapmode == 2 && $urandom_range(2) == 0));
         if (k != NW - 1) mon();
      end
      send_word(fck, 1'b0);
      good = (fck == model_xor());
      if (good) begin
         exp_cfg    = model_cfg();
         exp_loaded = 1'b1;
      end else begin
         exp_err = 1'b1;
      end
   endtask

   task automatic chk_idle_state(input string nm);
      chkv({nm, "_cfg"}, cfg_out, exp_cfg);
      chk1({nm, "_loaded"}, cfg_loaded, exp_loaded);
      chk1({nm, "_err"}, err, exp_err);
      chk1({nm, "_busy"}, busy, 1'b0);
      chk1({nm, "_ready"}, in_ready, 1'b0);
   endtask

   task automatic chk_reset(input string nm);
      chkv({nm, "_cfg"}, cfg_out, '0);
      chk1({nm, "_loaded"}, cfg_loaded, 1'b0);
      chk1({nm, "_err"}, err, 1'b0);
      chk1({nm, "_busy"}, busy, 1'b0);
      chk1({nm, "_ready"}, in_ready, 1'b0);
   endtask

   vec_t vecs [6];

   initial begin
      vecs[0] = '{idx: 0,   val: 8'h10, bad: 1'b0, exp_loaded: 1'b1, exp_err: 1'b0};
      vecs[1] = '{idx: 112, val: 8'hF5, bad: 1'b0, exp_loaded: 1'b1, exp_err: 1'b0};
      vecs[2] = '{idx: 0,   val: 8'h10, bad: 1'b0, exp_loaded: 1'b1, exp_err: 1'b0};
      vecs[3] = '{idx: 0,   val: 8'h01, bad: 1'b1, exp_loaded: 1'b1, exp_err: 1'b1};
      vecs[4] = '{idx: 57,  val: 8'hA3, bad: 1'b0, exp_loaded: 1'b1, exp_err: 1'b0};
      vecs[5] = '{idx: 33,  val: 8'hFF, bad: 1'b1, exp_loaded: 1'b1, exp_err: 1'b1};

      rst        = 1'b1;
      start      = 1'b0;
      in_valid   = 1'b0;
      in_data    = '0;
      exp_cfg    = '0;
      exp_loaded = 1'b0;
      exp_err    = 1'b0;
      glitch     = 1'b0;

      for (int c = 0; c < 2; c++) begin
         @(negedge clk);
         in_valid = 1'($urandom);
         in_data  = WW'($urandom);
      end
      @(negedge clk);
      chk_reset("reset");
      rst      = 1'b0;
      in_valid = 1'b0;

      // Directed frame table
      for (int v = 0; v < 6; v++) begin
         for (int k = 0; k < NW; k++) fw[k] = '0;
         fw[vecs[v].idx] = vecs[v].val;
         fck = vecs[v].val ^ (vecs[v].bad ? 8'h01 : 8'h00);
         run_frame(0, 1'b0);
         chkv($sformatf("vec%0d_cfg", v), cfg_out, exp_cfg);
         chk1($sformatf("vec%0d_loaded", v), cfg_loaded, vecs[v].exp_loaded);
         chk1($sformatf("vec%0d_err", v), err, vecs[v].exp_err);
         chk1($sformatf("vec%0d_busy", v), busy, 1'b0);
         chk1($sformatf("vec%0d_noglitch", v), glitch, 1'b0);
         if (v == 0) chk1("vec0_bit4", cfg_out[4], 1'b1);
         if (v == 1) chkn("vec1_tail", int'(cfg_out[899:896]), 5);
         if (v == 3) begin
            chk1("vec3_bit4_held", cfg_out[4], 1'b1);
            chk1("vec3_bit0_clear", cfg_out[0], 1'b0);
         end
      end

      // in_valid while idle must be ignored
      hs_cnt = 0;
      for (int c = 0; c < 4; c++) begin
         in_valid = 1'b1;
         in_data  = WW'($urandom);
         @(posedge clk);
         @(negedge clk);
      end
      in_valid = 1'b0;
      chkn("idle_handshakes", hs_cnt, 0);
      chk_idle_state("idle_valid");

      // Flow control: in_valid every other cycle over a full frame
      for (int k = 0; k < NW; k++) fw[k] = WW'($urandom);
      fck    = model_xor();
      hs_cnt = 0;
      run_frame(1, 1'b0);
      chkn("flow_accepted", hs_cnt, NW + 1);
      chk_idle_state("flow");
      chk1("flow_noglitch", glitch, 1'b0);

      // Abort after 50 words; restart pulse carries a word that must be dropped
      glitch = 1'b0;
      do_start(1'b0);
      for (int k = 0; k < 50; k++) send_word(WW'($urandom), 1'b0);
      for (int k = 0; k < NW; k++) fw[k] = WW'($urandom);
      fck = model_xor();
      run_frame(0, 1'b1);
      chk_idle_state("abort");

      // Reset after 60 words
      glitch = 1'b0;
      do_start(1'b0);
      for (int k = 0; k < 60; k++) send_word(WW'($urandom), 1'b0);
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      chk_reset("midrst");
      rst        = 1'b0;
      exp_cfg    = '0;
      exp_loaded = 1'b0;
      exp_err    = 1'b0;

      // Randomized frames
      for (int r = 0; r < 8; r++) begin
         for (int k = 0; k < NW; k++) fw[k] = WW'($urandom);
         fck = model_xor();
         if ($urandom_range(3) == 0) fck = fck ^ WW'($urandom_range(255, 1));
         run_frame(2, 1'($urandom));
         chk_idle_state($sformatf("rand%0d", r));
         chk1($sformatf("rand%0d_noglitch", r), glitch, 1'b0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #3_000_000;
      $display("FAIL watchdog: actual timeout required completion");
      $fatal(1, "watchdog expired");
   end

endmodule
